scroll_fetch: RTL and testbench

SCROLL_FETCH -- requirements
Module: scroll_fetch

---
 rtl/scroll_fetch_pkg.sv | 36 +++
 rtl/scroll_fetch_if.sv | 10 +
 rtl/scroll_fetch.sv | 139 +++++++++++++
 tb/tb_scroll_fetch.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/scroll_fetch_pkg.sv
// Shared constants for the scroll RAM fetch sequencer (package scroll_pkg):
// scroll RAM address map, fetch FSM state encodings and the slot start phase.
package scroll_pkg;

  localparam int unsigned ADDR_W = 11;

  localparam logic [ADDR_W-1:0] BASE_HA_LO = 11'h000;
  localparam logic [ADDR_W-1:0] BASE_HA_HI = 11'h100;
  localparam logic [ADDR_W-1:0] BASE_HB_LO = 11'h200;
  localparam logic [ADDR_W-1:0] BASE_HB_HI = 11'h300;
  localparam logic [ADDR_W-1:0] BASE_VA    = 11'h400;
  localparam logic [ADDR_W-1:0] BASE_VB    = 11'h440;

  // {pixel parity, MCLK phase} value that opens a 2-pixel fetch slot
  localparam logic [3:0] SLOT_START_PHASE = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HA_LO = 3'd1,
    ST_HA_HI = 3'd2,
    ST_HB_LO = 3'd3,
    ST_HB_HI = 3'd4,
    ST_HDONE = 3'd5,
    ST_VCOL  = 3'd6
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [7:0] idx);
    return base | {3'b000, idx};
  endfunction

  function automatic logic [ADDR_W-1:0] col_addr(input logic layer_b, input logic [5:0] col);
    return (layer_b ? BASE_VB : BASE_VA) | {5'b00000, col};
  endfunction

endpackage

// File: rtl/scroll_fetch_if.sv
// Scroll RAM GFX read port: address out from the fetcher, readout data back.
interface scroll_fetch_if;
  import scroll_pkg::*;

  logic [ADDR_W-1:0] o_GFXADDR;
  logic [7:0]        i_SCRRAM_DATA;

  modport master (output o_GFXADDR, input  i_SCRRAM_DATA);
  modport slave  (input  o_GFXADDR, output i_SCRRAM_DATA);
endinterface

// File: rtl/scroll_fetch.sv
// Scroll RAM fetch sequencer: line HSCROLL fetch inside the VCLK window, column VSCROLL fetch outside it.
// Build macro SCROLL_FETCH_FLIP_EN: mirror line/column indices when i_FLIP is set.
//
// state    | meaning
// IDLE     | after reset / VCLK high without a seen rising edge; no fetch
// HA_LO    | presenting TM-A HSCROLL low byte address
// HA_HI    | presenting TM-A HSCROLL high bit address
// HB_LO    | presenting TM-B HSCROLL low byte address
// HB_HI    | presenting TM-B HSCROLL high bit address
// HDONE    | line fetch complete, address held, waiting for VCLK fall to commit
// VCOL     | VCLK low, fetching next column VSCROLL for TM-A / TM-B
module scroll_fetch
  import scroll_pkg::*;
(
  input  logic           i_EMU_MCLK,
  input  logic           i_EMU_MRST_n,
  input  logic [4:0]     i_EMU_TIMING,
  input  logic [8:0]     i_HCNTR,
  input  logic [7:0]     i_VCNTR,
  input  logic           i_VCLK,
  input  logic           i_FLIP,
  scroll_fetch_if.master scr_bus,
  output logic [8:0]     o_TMA_HSCROLL,
  output logic [8:0]     o_TMB_HSCROLL,
  output logic [7:0]     o_TMA_VSCROLL,
  output logic [7:0]     o_TMB_VSCROLL
);

  fetch_state_e      state_q, state_d;
  logic              vclk_q, edge_ok_q, rise_pend_q;
  logic              slot_start, vclk_rise, vclk_fall, rise_seen;
  logic [5:0]        col_next, col_idx;
  logic [7:0]        line_idx;
  logic [ADDR_W-1:0] addr_q;
  logic              vcol_layer_q;
  logic [8:0]        sh_tma_q, sh_tmb_q;
  logic              unused_sig;

  assign slot_start = (i_EMU_TIMING[3:0] == SLOT_START_PHASE);
  // edge_ok_q masks the first cycle after reset so a VCLK already high is not seen as a rise
  assign vclk_rise  = edge_ok_q & i_VCLK & ~vclk_q;
  assign vclk_fall  = edge_ok_q & ~i_VCLK & vclk_q;
  assign rise_seen  = vclk_rise | rise_pend_q;
  assign col_next   = i_HCNTR[8:3] + 6'd1;

`ifdef SCROLL_FETCH_FLIP_EN
  assign line_idx   = i_FLIP ? ~i_VCNTR : i_VCNTR;
  assign col_idx    = i_FLIP ? ~col_next : col_next;
  assign unused_sig = ^{i_EMU_TIMING[4], i_HCNTR[1:0]};
`else
  assign line_idx   = i_VCNTR;
  assign col_idx    = col_next;
  assign unused_sig = ^{i_EMU_TIMING[4], i_HCNTR[1:0], i_FLIP};
`endif

  assign scr_bus.o_GFXADDR = addr_q;

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      vclk_q      <= 1'b0;
      edge_ok_q   <= 1'b0;
      rise_pend_q <= 1'b0;
    end else begin
      vclk_q    <= i_VCLK;
      edge_ok_q <= 1'b1;
      if (slot_start || vclk_fall) rise_pend_q <= 1'b0;
      else if (vclk_rise)          rise_pend_q <= 1'b1;
    end
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) state_q <= ST_IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (slot_start) begin
      if (!i_VCLK)        state_d = ST_VCOL;
      else if (rise_seen) state_d = ST_HA_LO;
      else begin
        case (state_q)
          ST_HA_LO: state_d = ST_HA_HI;
          ST_HA_HI: state_d = ST_HB_LO;
          ST_HB_LO: state_d = ST_HB_HI;
          ST_HB_HI: state_d = ST_HDONE;
          ST_HDONE: state_d = ST_HDONE;
          default:  state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Captures are keyed on state_q: the data returning now belongs to the address of the slot just ended.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      addr_q        <= '0;
      vcol_layer_q  <= 1'b0;
      sh_tma_q      <= '0;
      sh_tmb_q      <= '0;
      o_TMA_HSCROLL <= '0;
      o_TMB_HSCROLL <= '0;
      o_TMA_VSCROLL <= '0;
      o_TMB_VSCROLL <= '0;
    end else begin
      if (slot_start) begin
        case (state_q)
          ST_HA_LO: sh_tma_q[7:0] <= scr_bus.i_SCRRAM_DATA;
          ST_HA_HI: sh_tma_q[8]   <= scr_bus.i_SCRRAM_DATA[0];
          ST_HB_LO: sh_tmb_q[7:0] <= scr_bus.i_SCRRAM_DATA;
          ST_HB_HI: sh_tmb_q[8]   <= scr_bus.i_SCRRAM_DATA[0];
          ST_VCOL: begin
            if (vcol_layer_q) o_TMB_VSCROLL <= scr_bus.i_SCRRAM_DATA;
            else              o_TMA_VSCROLL <= scr_bus.i_SCRRAM_DATA;
          end
          default: ;
        endcase

        case (state_d)
          ST_HA_LO: addr_q <= line_addr(BASE_HA_LO, line_idx);
          ST_HA_HI: addr_q <= line_addr(BASE_HA_HI, line_idx);
          ST_HB_LO: addr_q <= line_addr(BASE_HB_LO, line_idx);
          ST_HB_HI: addr_q <= line_addr(BASE_HB_HI, line_idx);
          ST_VCOL: begin
            addr_q       <= col_addr(i_HCNTR[2], col_idx);
            vcol_layer_q <= i_HCNTR[2];
          end
          default: ;
        endcase
      end

      if (vclk_fall && state_q == ST_HDONE) begin
        o_TMA_HSCROLL <= sh_tma_q;
        o_TMB_HSCROLL <= sh_tmb_q;
      end
    end
  end

endmodule

// File: tb/tb_scroll_fetch.sv
// Directed self-checking bench for scroll_fetch: VCOL vector table plus HSCROLL window, abort, reset and flip sequences.
`timescale 1ns/1ps
module tb_scroll_fetch;
  import scroll_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  timing;
  logic [8:0]  hcntr = 9'h1F8;
  logic [7:0]  vcntr = 8'h12;
  logic        vclk = 1'b0;
  logic        flip = 1'b0;
  logic [8:0]  tma_h, tmb_h;
  logic [7:0]  tma_v, tmb_v;
  logic [7:0]  mem [0:2047];
  int          tcnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  scroll_fetch_if bus();
  assign bus.i_SCRRAM_DATA = mem[bus.o_GFXADDR];

  scroll_fetch dut (
    .i_EMU_MCLK   (clk),
    .i_EMU_MRST_n (rst_n),
    .i_EMU_TIMING (timing),
    .i_HCNTR      (hcntr),
    .i_VCNTR      (vcntr),
    .i_VCLK       (vclk),
    .i_FLIP       (flip),
    .scr_bus      (bus),
    .o_TMA_HSCROLL(tma_h),
    .o_TMB_HSCROLL(tmb_h),
    .o_TMA_VSCROLL(tma_v),
    .o_TMB_VSCROLL(tmb_v)
  );

  always #5 clk = ~clk;

  // 12 MCLK per slot: 2 pixels x 6 phases
  always @(posedge clk) tcnt <= (tcnt == 11) ? 0 : tcnt + 1;
  assign timing = {1'b0, (tcnt >= 6), 3'(tcnt % 6)};

  typedef struct {
    logic [8:0]  hcntr;
    logic [7:0]  data;
    logic [10:0] exp_addr;
    logic        exp_b;
  } vcol_vec_t;

  vcol_vec_t vec [6];

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // returns #1 after the edge that opened a slot
  task automatic next_slot();
    do begin @(posedge clk); #1; end while (tcnt != 1);
  endtask

  // returns #1 after the edge preceding a slot start edge
  task automatic to_pre_slot();
    do begin @(posedge clk); #1; end while (tcnt != 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gfxaddr"}, bus.o_GFXADDR, 11'h000);
    check({tag, "_tma_h"}, tma_h, 11'h000);
    check({tag, "_tmb_h"}, tmb_h, 11'h000);
    check({tag, "_tma_v"}, tma_v, 11'h000);
    check({tag, "_tmb_v"}, tmb_v, 11'h000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[11'h000] = 8'h5A;

    vec[0] = '{9'h1F8, 8'h11, 11'h400, 1'b0};
    vec[1] = '{9'h004, 8'h7A, 11'h441, 1'b1};
    vec[2] = '{9'h000, 8'h22, 11'h401, 1'b0};
    vec[3] = '{9'h0FC, 8'h9C, 11'h460, 1'b1};
    vec[4] = '{9'h1F0, 8'hE5, 11'h43F, 1'b0};
    vec[5] = '{9'h1FC, 8'h3C, 11'h440, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");

    // release with VCLK low: first slot goes VCOL, no capture yet
    mem[11'h400] = 8'h11;
    rst_n = 1'b1;
    next_slot();
    check("release_vcol_wrap_addr", bus.o_GFXADDR, 11'h400);
    check("release_no_capture_a", tma_v, 11'h000);
    check("release_no_capture_b", tmb_v, 11'h000);

    for (int i = 0; i < 6; i++) begin
      hcntr = vec[i].hcntr;
      mem[vec[i].exp_addr] = vec[i].data;
      next_slot();
      check($sformatf("vcol_addr[%0d]", i), bus.o_GFXADDR, vec[i].exp_addr);
      next_slot();
      check($sformatf("vcol_data[%0d]", i), vec[i].exp_b ? tmb_v : tma_v, {3'b000, vec[i].data});
    end

    // 6-slot VCLK pulse, V=0x12
    mem[11'h012] = 8'h34;
    mem[11'h112] = 8'h01;
    mem[11'h212] = 8'h56;
    mem[11'h312] = 8'h00;
    vclk = 1'b1;
    next_slot();
    check("ha_lo_addr", bus.o_GFXADDR, 11'h012);
    next_slot();
    check("ha_hi_addr", bus.o_GFXADDR, 11'h112);
    next_slot();
    check("hb_lo_addr", bus.o_GFXADDR, 11'h212);
    next_slot();
    check("hb_hi_addr", bus.o_GFXADDR, 11'h312);
    next_slot();
    check("hdone_hold_addr", bus.o_GFXADDR, 11'h312);
    next_slot();
    check("hdone_hold_addr2", bus.o_GFXADDR, 11'h312);
    check("precommit_tma_h", tma_h, 11'h000);
    check("precommit_tmb_h", tmb_h, 11'h000);
    vclk = 1'b0;
    @(posedge clk); #1;
    check("commit_tma_h", tma_h, 11'h134);
    check("commit_tmb_h", tmb_h, 11'h056);

    // 3-slot pulse, rise coincident with slot start: no commit
    next_slot();
    check("after_fall_vcol_addr", bus.o_GFXADDR, 11'h440);
    vcntr = 8'h40;
    mem[11'h040] = 8'hAA;
    mem[11'h140] = 8'h01;
    mem[11'h240] = 8'hBB;
    to_pre_slot();
    vclk = 1'b1;
    @(posedge clk); #1;
    check("coincident_rise_ha_lo", bus.o_GFXADDR, 11'h040);
    next_slot();
    check("short_ha_hi", bus.o_GFXADDR, 11'h140);
    next_slot();
    check("short_hb_lo", bus.o_GFXADDR, 11'h240);
    vclk = 1'b0;
    next_slot();
    check("abort_vcol_addr", bus.o_GFXADDR, 11'h440);
    check("abort_hold_tma_h", tma_h, 11'h134);
    check("abort_hold_tmb_h", tmb_h, 11'h056);

    // reset asserted mid-HB_LO
    vclk = 1'b1;
    next_slot();
    next_slot();
    next_slot();
    check("pre_reset_hb_lo", bus.o_GFXADDR, 11'h240);
    @(posedge clk); #3;
    rst_n = 1'b0;
    vclk  = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    hcntr = 9'h004;
    next_slot();
    check("rerelease_addr", bus.o_GFXADDR, 11'h441);
    check("rerelease_no_capture_a", tma_v, 11'h000);
    check("rerelease_no_capture_b", tmb_v, 11'h000);
    next_slot();
    check("rerelease_tmb_v", tmb_v, 11'h07A);

    // flip on HA_LO with V=0
    flip  = 1'b1;
    vcntr = 8'h00;
    vclk  = 1'b1;
    next_slot();
`ifdef SCROLL_FETCH_FLIP_EN
    check("flip_ha_lo_addr", bus.o_GFXADDR, 11'h0FF);
`else
    check("flip_ignored_ha_lo_addr", bus.o_GFXADDR, 11'h000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
